// File: rtl/ami_pkg.sv
// Shared constants and state encoding for the AXI master write path.
// Both the AW splitter and the write packer use these, so their burst partitions stay identical.
package ami_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } wpack_state_e;

  localparam int AXI_BYTES_DEF = 16;
  localparam int BL            = 16;
  localparam int L             = $clog2(AXI_BYTES_DEF);
  localparam int B             = $clog2(BL) + L;

endpackage

// File: rtl/ami_wrealign.sv
// Combinational lane realignment of {src_data, residual} by the start offset, plus first/last strobes.
// AMI_WPACK_UNALIGNED_EN enables the shifter; without it data passes straight through.
module ami_wrealign
  import ami_pkg::*;
#(
  parameter int AXI_BYTES = 16,
  parameter int L         = $clog2(AXI_BYTES)
) (
  input  logic [8*AXI_BYTES-1:0] src_data,
`ifdef AMI_WPACK_UNALIGNED_EN
  input  logic [8*AXI_BYTES-1:0] resid,
`endif
  input  logic [L-1:0]           o,
  input  logic                   first,
  input  logic                   last,
  input  logic [L-1:0]           end_lane,
  output logic [8*AXI_BYTES-1:0] data,
  output logic [AXI_BYTES-1:0]   strb
);

`ifdef AMI_WPACK_UNALIGNED_EN
  logic [16*AXI_BYTES-1:0] cat;
  assign cat = {src_data, resid};
`endif

  for (genvar gi = 0; gi < AXI_BYTES; gi++) begin : g_lane
`ifdef AMI_WPACK_UNALIGNED_EN
    // Output lane gi takes byte (AXI_BYTES - o + gi) of the residual:source pair.
    logic [L:0] idx;
    assign idx = (L+1)'(AXI_BYTES + gi) - {1'b0, o};
    assign data[gi*8 +: 8] = cat[{idx, 3'b000} +: 8];
`else
    assign data[gi*8 +: 8] = src_data[gi*8 +: 8];
`endif
    assign strb[gi] = (!first || (L'(gi) >= o)) && (!last || (L'(gi) <= end_lane));
  end

endmodule

// File: rtl/ami_wpack.sv
// Write-data packer: turns a lane-0-aligned source stream into address-aligned W beats with burst wlast.
// AMI_WPACK_UNALIGNED_EN adds support for unaligned start addresses (shifter, residual, DRAIN).
module ami_wpack
  import ami_pkg::*;
#(
  parameter int AXI_DW     = 128,
  parameter int AXI_BYTES  = AXI_DW / 8,
  parameter int AXI_WSTRBW = AXI_BYTES,
  parameter int BL         = ami_pkg::BL,
  parameter int L          = $clog2(AXI_BYTES),
  parameter int B          = $clog2(BL) + L
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [31:0]           cfg_sa,
  input  logic [31:0]           cfg_len,
  input  logic [AXI_DW-1:0]     src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [AXI_DW-1:0]     usr_wdata,
  output logic [AXI_WSTRBW-1:0] usr_wstrb,
  output logic                  usr_wlast,
  output logic                  usr_wvalid,
  input  logic                  usr_wready,
  output logic                  busy
);

  localparam int CW = 33 - L;

  wpack_state_e          state_q, state_d;
  logic                  rdy_q;
  logic [L-1:0]          o_q, o_d, end_q, end_d;
  logic [B-L-1:0]        blk_q, blk_d;
  logic [CW-1:0]         beats_q, beats_d, words_q, words_d;
  logic                  first_q, first_d;
  logic [AXI_DW-1:0]     wdata_q, wdata_d;
  logic [AXI_WSTRBW-1:0] wstrb_q, wstrb_d;
  logic                  wlast_q, wlast_d, wvalid_q, wvalid_d;

  logic [L-1:0]          sa_off;
  logic [32:0]           span;
  logic [CW-1:0]         nbeat, nsrc;
  logic                  cfg_fire, src_fire, slot_free, emit, beat_last;
  logic [AXI_DW-1:0]     al_data;
  logic [AXI_WSTRBW-1:0] al_strb;
  logic                  unused_cfg;

`ifdef AMI_WPACK_UNALIGNED_EN
  logic [AXI_DW-1:0] resid_q;
  assign sa_off = cfg_sa[L-1:0];
`else
  assign sa_off = '0;
`endif

  assign unused_cfg = ^{cfg_sa[31:B], cfg_sa[L-1:0]};
  assign span       = {1'b0, cfg_len} + 33'(sa_off);
  assign nbeat      = CW'((span + 33'(AXI_BYTES - 1)) >> L);
  assign nsrc       = CW'(({1'b0, cfg_len} + 33'(AXI_BYTES - 1)) >> L);

  assign cfg_ready  = rdy_q && (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign slot_free  = !wvalid_q || usr_wready;
  assign src_ready  = (state_q == XFER) && (words_q != '0) && slot_free;
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign src_fire   = src_valid && src_ready;
  assign beat_last  = (beats_q == CW'(1));

  assign usr_wdata  = wdata_q;
  assign usr_wstrb  = wstrb_q;
  assign usr_wlast  = wlast_q;
  assign usr_wvalid = wvalid_q;

  ami_wrealign #(
    .AXI_BYTES (AXI_BYTES),
    .L         (L)
  ) u_realign (
    .src_data (src_data),
`ifdef AMI_WPACK_UNALIGNED_EN
    .resid    (resid_q),
`endif
    .o        (o_q),
    .first    (first_q),
    .last     (beat_last),
    .end_lane (end_q),
    .data     (al_data),
    .strb     (al_strb)
  );

  always_comb begin
    state_d  = state_q;
    o_d      = o_q;
    end_d    = end_q;
    blk_d    = blk_q;
    beats_d  = beats_q;
    words_d  = words_q;
    first_d  = first_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wlast_d  = wlast_q;
    wvalid_d = wvalid_q;
    emit     = 1'b0;

    if (wvalid_q && usr_wready) wvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_fire && (cfg_len != '0)) begin
          o_d     = sa_off;
          end_d   = sa_off + cfg_len[L-1:0] - L'(1);
          blk_d   = cfg_sa[B-1:L];
          beats_d = nbeat;
          words_d = nsrc;
          first_d = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (src_fire) begin
          emit    = 1'b1;
          words_d = words_q - CW'(1);
          // One beat more than source words means the residual still holds the tail.
          if ((words_q == CW'(1)) && !beat_last) state_d = DRAIN;
        end else if ((words_q == '0) && wvalid_q && usr_wready) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (beats_q != '0) begin
          emit = slot_free;
        end else if (usr_wready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      wvalid_d = 1'b1;
      wdata_d  = al_data;
      wstrb_d  = al_strb;
      wlast_d  = (&blk_q) || beat_last;
      blk_d    = blk_q + 1'b1;
      beats_d  = beats_q - CW'(1);
      first_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      o_q      <= '0;
      end_q    <= '0;
      blk_q    <= '0;
      beats_q  <= '0;
      words_q  <= '0;
      first_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      o_q      <= o_d;
      end_q    <= end_d;
      blk_q    <= blk_d;
      beats_q  <= beats_d;
      words_q  <= words_d;
      first_q  <= first_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wlast_q  <= wlast_d;
      wvalid_q <= wvalid_d;
    end
  end

`ifdef AMI_WPACK_UNALIGNED_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resid_q <= '0;
    end else if (src_fire) begin
      resid_q <= src_data;
    end
  end
`endif

endmodule

// File: tb/tb_ami_wpack.sv
// Randomized self-checking bench for ami_wpack against a byte-level reference model.
// Honours AMI_WPACK_UNALIGNED_EN: without it the model forces the start offset to zero.
module tb_ami_wpack;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_valid, cfg_ready;
  logic [31:0]  cfg_sa, cfg_len;
  logic [127:0] src_data;
  logic         src_valid, src_ready;
  logic [127:0] usr_wdata;
  logic [15:0]  usr_wstrb;
  logic         usr_wlast, usr_wvalid, usr_wready;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb [0:1023];
  int         cur_o, cur_len, cur_nbeat, cur_nsrc;
  logic [31:0] cur_a0;

  always #5 clk = ~clk;

  ami_wpack dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_sa     (cfg_sa),
    .cfg_len    (cfg_len),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .usr_wdata  (usr_wdata),
    .usr_wstrb  (usr_wstrb),
    .usr_wlast  (usr_wlast),
    .usr_wvalid (usr_wvalid),
    .usr_wready (usr_wready),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat k of the current descriptor, derived directly from the byte-position rules.
  function automatic void exp_beat(input int k, output logic [127:0] d, output logic [15:0] s,
                                   output logic l);
    d = '0;
    s = '0;
    for (int j = 0; j < 16; j++) begin
      int p;
      p = k * 16 + j - cur_o;
      if (p >= 0 && p < cur_len) begin
        s[j] = 1'b1;
        d[j*8 +: 8] = sb[p];
      end
    end
    l = ((((cur_a0 >> 4) + 32'(k)) % 16) == 15) || (k == cur_nbeat - 1);
  endfunction

  task automatic issue_cfg(input logic [31:0] sa, input int len);
    int n;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_sa    = sa;
    cfg_len   = 32'(len);
    #1;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("cfg_ready_accept", 128'(cfg_ready), 128'(1));
  endtask

  // rmode: 0 always ready, 1 toggle 1/0, 2 random. vmode: 0 continuous source, 1 random gaps.
  task automatic run_xfer(input logic [31:0] sa, input int len, input int rmode, input int vmode,
                          input bit ramp, input int stop_after);
    int beats_seen, word_idx, cyc;
    logic [127:0] ed, md;
    logic [15:0]  es;
    logic         el;
    beats_seen = 0;
    word_idx   = 0;
    cyc        = 0;
    cur_len    = len;
    cur_a0     = sa & ~32'hF;
`ifdef AMI_WPACK_UNALIGNED_EN
    cur_o      = int'(sa[3:0]);
`else
    cur_o      = 0;
`endif
    cur_nbeat  = (cur_o + len + 15) / 16;
    cur_nsrc   = (len + 15) / 16;
    for (int i = 0; i < 1024; i++) sb[i] = ramp ? 8'(i) : 8'($urandom);
    issue_cfg(sa, len);
    while (beats_seen < cur_nbeat && cyc < 20 * cur_nbeat + 50 &&
           !(stop_after >= 0 && beats_seen >= stop_after)) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      case (rmode)
        0:       usr_wready = 1'b1;
        1:       usr_wready = (cyc % 2 == 0);
        default: usr_wready = 1'($urandom_range(0, 1));
      endcase
      src_valid = (word_idx < cur_nsrc) && (vmode == 0 || $urandom_range(0, 3) != 0);
      for (int i = 0; i < 16; i++)
        src_data[i*8 +: 8] = (word_idx < cur_nsrc) ? sb[word_idx*16 + i] : 8'($urandom);
      #1;
      if (word_idx >= cur_nsrc) check_val("src_overrun", 128'(src_ready), 128'(0));
      if (src_valid && src_ready) word_idx++;
      if (usr_wvalid) begin
        exp_beat(beats_seen, ed, es, el);
        for (int j = 0; j < 16; j++) md[j*8 +: 8] = es[j] ? usr_wdata[j*8 +: 8] : 8'h00;
        check_val($sformatf("wstrb_b%0d", beats_seen), 128'(usr_wstrb), 128'(es));
        check_val($sformatf("wdata_b%0d", beats_seen), md, ed);
        check_val($sformatf("wlast_b%0d", beats_seen), 128'(usr_wlast), 128'(el));
        if (usr_wready) beats_seen++;
      end
      cyc++;
    end
    if (stop_after < 0) begin
      check_val("beat_count", 128'(beats_seen), 128'(cur_nbeat));
      check_val("word_count", 128'(word_idx), 128'(cur_nsrc));
      @(negedge clk);
      src_valid  = 1'b0;
      usr_wready = 1'b1;
      #1;
      check_val("cfg_ready_done", 128'(cfg_ready), 128'(1));
      check_val("busy_done", 128'(busy), 128'(0));
      check_val("wvalid_done", 128'(usr_wvalid), 128'(0));
    end
    $display("xfer sa=%08h len=%0d o=%0d beats=%0d/%0d words=%0d rmode=%0d", sa, len, cur_o,
             beats_seen, cur_nbeat, word_idx, rmode);
  endtask

  initial begin
    reset_n    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_sa     = '0;
    cfg_len    = '0;
    src_data   = '0;
    src_valid  = 1'b0;
    usr_wready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_cfg_ready", 128'(cfg_ready), 128'(0));
    check_val("rst_src_ready", 128'(src_ready), 128'(0));
    check_val("rst_wvalid", 128'(usr_wvalid), 128'(0));
    check_val("rst_wlast", 128'(usr_wlast), 128'(0));
    check_val("rst_wdata", usr_wdata, 128'(0));
    check_val("rst_wstrb", 128'(usr_wstrb), 128'(0));
    check_val("rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("post_rst_cfg_ready", 128'(cfg_ready), 128'(1));

    run_xfer(32'h0000_1000, 64, 0, 0, 1'b0, -1);
    run_xfer(32'h0000_1003, 16, 0, 0, 1'b1, -1);
    run_xfer(32'h0000_10F0, 32, 0, 0, 1'b0, -1);
    run_xfer(32'h0000_1000, 512, 0, 0, 1'b0, -1);
    run_xfer(32'h0000_1000, 512, 1, 0, 1'b0, -1);

    // Zero-length descriptor: accepted, nothing emitted, ready again next cycle.
    issue_cfg(32'h0000_3000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      check_val("len0_cfg_ready", 128'(cfg_ready), 128'(1));
      check_val("len0_wvalid", 128'(usr_wvalid), 128'(0));
    end
    $display("xfer sa=00003000 len=0 beats=0");

    // Reset in the middle of a long transfer, then a fresh transfer.
    run_xfer(32'h0000_1000, 512, 0, 0, 1'b0, 10);
    @(negedge clk);
    reset_n   = 1'b0;
    src_valid = 1'b0;
    #1;
    check_val("midrst_wvalid", 128'(usr_wvalid), 128'(0));
    check_val("midrst_busy", 128'(busy), 128'(0));
    check_val("midrst_src_ready", 128'(src_ready), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("midrst_cfg_ready", 128'(cfg_ready), 128'(1));
    run_xfer(32'h0000_1000, 512, 0, 0, 1'b0, -1);

    for (int t = 0; t < 40; t++) begin
      run_xfer(32'h0000_4000 + 32'($urandom_range(0, 1023)), int'($urandom_range(1, 300)),
               2, 1, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
